// File: rtl/display_scan_controller_if.sv
// Load channel for display_scan_controller: a new set of digit nibbles and
// decimal points offered with a valid/ready handshake.
interface display_scan_controller_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load_valid;
  logic                load_ready;

  modport master (
    output value_in,
    output dp_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed common-anode 7-segment scanner: blank gap, then one digit on per
// slot, with frame-aligned commit of a shadow register and leading-zero blanking.
module display_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 lz_blank_en,
  display_scan_controller_if.slave load,
  output logic [3:0]           code,
  output logic [DIGITS-1:0]    anode_n,
  output logic                 dp_n,
  output logic                 frame_tick
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIG_W   = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [4*DIGITS-1:0]   active_val_q, active_val_d;
  logic [DIGITS-1:0]     active_dp_q, active_dp_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic [3:0]            code_q, code_d;
  logic [DIGITS-1:0]     anode_n_q, anode_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  load_ready_int;
  logic                  enter_frame;
  logic                  digit_blanked;
  logic [DIGITS-1:0]     nib_zero;
  logic [DIGITS-1:0]     lz_mask;

  assign load_ready_int  = !pend_full_q && !rst;
  assign load.load_ready = load_ready_int;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_zero
    assign nib_zero[gi] = (active_val_q[gi*4 +: 4] == 4'd0);
  end

  // lz_mask[i] is set when every nibble from i up to the top digit is zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && nib_zero[i];
      lz_mask[i] = zero_run;
    end
  end

  assign digit_blanked = lz_blank_en && (digit_q != '0) && lz_mask[digit_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;
    code_d       = code_q;
    anode_n_d    = anode_n_q;
    dp_n_d       = dp_n_q;
    frame_tick_d = 1'b0;
    enter_frame  = 1'b0;

    if (load.load_valid && load_ready_int) begin
      pend_val_d  = load.value_in;
      pend_dp_d   = load.dp_in;
      pend_full_d = 1'b1;
    end

    if (!enable) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      digit_d   = '0;
      anode_n_d = '1;
      dp_n_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_BLANK;
          cnt_d       = '0;
          digit_d     = '0;
          enter_frame = 1'b1;
          anode_n_d   = '1;
          dp_n_d      = 1'b1;
        end
        S_BLANK: begin
          anode_n_d = '1;
          dp_n_d    = 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
            if (!digit_blanked) begin
              anode_n_d = ~(DIGITS'(1) << digit_q);
              dp_n_d    = !active_dp_q[digit_q];
            end
            if (DWELL == 1 && digit_q == DIG_LAST) frame_tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d   = S_BLANK;
            cnt_d     = '0;
            anode_n_d = '1;
            dp_n_d    = 1'b1;
            if (digit_q == DIG_LAST) begin
              digit_d     = '0;
              enter_frame = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (digit_q == DIG_LAST && cnt_d == DWELL_LAST) frame_tick_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A load accepted on this same edge cannot collide: ready is low while full.
    if (enter_frame && pend_full_q) begin
      active_val_d = pend_val_q;
      active_dp_d  = pend_dp_q;
      pend_full_d  = 1'b0;
    end

    if (enable && state_d == S_BLANK && state_q != S_BLANK)
      code_d = active_val_d[{digit_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      digit_q      <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      code_q       <= 4'd0;
      anode_n_q    <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      code_q       <= code_d;
      anode_n_q    <= anode_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign code       = code_q;
  assign anode_n    = anode_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized self-checking bench: a frame-position model predicts every output
// cycle by cycle; scenario tasks add targeted checks on top.
module tb_display_scan_controller;
  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = BLANK + DWELL;
  localparam int FRAME  = DIGITS * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic lz_blank_en = 1'b0;
  logic [3:0] code;
  logic [DIGITS-1:0] anode_n;
  logic dp_n;
  logic frame_tick;

  display_scan_controller_if #(.DIGITS(DIGITS)) load_if ();

  display_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lz_blank_en (lz_blank_en),
    .load        (load_if.slave),
    .code        (code),
    .anode_n     (anode_n),
    .dp_n        (dp_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: position within the frame (-1 when idle) plus active/pending contents.
  int          m_pos = -1;
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_pend_dp = '0;
  logic        m_pend_full = 1'b0;
  logic [3:0]  m_code = '0;

  logic [10:0] act_vec;
  assign act_vec = {anode_n, dp_n, code, frame_tick, load_if.load_ready};

  function automatic logic [10:0] exp_vec();
    logic [3:0] an;
    logic dpn;
    logic tk;
    int slot;
    int ph;
    an = 4'hF;
    dpn = 1'b1;
    tk = 1'b0;
    if (m_pos >= 0) begin
      slot = m_pos / SLOT;
      ph = m_pos % SLOT;
      if (ph >= BLANK && !(lz_blank_en && slot >= 1 && (m_active >> (4 * slot)) == 16'd0)) begin
        an[slot] = 1'b0;
        dpn = !m_dp[slot];
      end
      tk = (m_pos == FRAME - 1);
    end
    return {an, dpn, m_code, tk, !m_pend_full && !rst};
  endfunction

  task automatic step();
    logic acc;
    logic [15:0] sh;
    @(posedge clk);
    acc = load_if.load_valid && !m_pend_full && !rst;
    if (rst) begin
      m_pos = -1;
      m_active = '0;
      m_dp = '0;
      m_pend_full = 1'b0;
      m_code = '0;
    end else begin
      if (!enable) m_pos = -1;
      else m_pos = (m_pos < 0) ? 0 : (m_pos + 1) % FRAME;
      if (m_pos == 0 && m_pend_full) begin
        m_active = m_pend;
        m_dp = m_pend_dp;
        m_pend_full = 1'b0;
      end
      if (acc) begin
        m_pend = load_if.value_in;
        m_pend_dp = load_if.dp_in;
        m_pend_full = 1'b1;
        $display("load accepted value=%h dp=%b", load_if.value_in, load_if.dp_in);
      end
      if (m_pos >= 0) begin
        sh = m_active >> (4 * (m_pos / SLOT));
        m_code = sh[3:0];
      end
    end
    #1;
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] d);
    load_if.value_in = v;
    load_if.dp_in = d;
    load_if.load_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.value_in = '0;
    load_if.dp_in = '0;
    repeat (3) step();
    checks++;
    if (act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", act_vec, exp_vec());
    end
    checks++;
    if (load_if.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", load_if.load_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (load_if.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", load_if.load_ready);
    end
  endtask

  task automatic test_scan();
    int ticks;
    logic [3:0] seen[$];
    offer(16'h1234, 4'b0000);
    step();
    load_if.load_valid = 1'b0;
    enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL scan cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
      end
      checks++;
      if ($countones(~anode_n) > 1) begin
        failures++;
        $display("FAIL scan_onehot cyc=%0d anode_n=%b exp=at most one low", i, anode_n);
      end
      if (frame_tick) ticks++;
      if (i < FRAME && i % SLOT == 0) seen.push_back(code);
    end
    checks++;
    if (ticks != 3) begin
      failures++;
      $display("FAIL scan_ticks got=%0d exp=3", ticks);
    end
    checks++;
    if ({seen[0], seen[1], seen[2], seen[3]} !== 16'h4321) begin
      failures++;
      $display("FAIL scan_codes got=%h%h%h%h exp=4321", seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  // Steps while checking every cycle until the model reaches frame position tgt.
  task automatic run_to(input int tgt, input string tag);
    for (int i = 0; i < 2 * FRAME && m_pos != tgt; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, i, act_vec, exp_vec());
      end
    end
    checks++;
    if (m_pos != tgt) begin
      failures++;
      $display("FAIL %s_timeout pos=%0d exp=%0d", tag, m_pos, tgt);
    end
  endtask

  task automatic test_handshake();
    run_to(10, "hs_wait");
    offer(16'hABCD, 4'b0000);
    step();
    offer(16'h5678, 4'b0000);
    checks++;
    if (load_if.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL hs_ready_after_accept got=%b exp=0", load_if.load_ready);
    end
    run_to(0, "hs_old_frame");
    checks++;
    if (code !== 4'hD) begin
      failures++;
      $display("FAIL hs_commit_code got=%h exp=d", code);
    end
    step();
    load_if.load_valid = 1'b0;
    checks++;
    if (load_if.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL hs_second_accept ready got=%b exp=0", load_if.load_ready);
    end
    run_to(0, "hs_second");
    checks++;
    if (code !== 4'h8) begin
      failures++;
      $display("FAIL hs_second_code got=%h exp=8", code);
    end
    run_to(FRAME - 1, "hs_defer_wait");
    offer(16'h9999, 4'b0000);
    step();
    load_if.load_valid = 1'b0;
    checks++;
    if (code !== 4'h8 || load_if.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL hs_deferred code=%h ready=%b exp code=8 ready=0", code, load_if.load_ready);
    end
    step();
    run_to(0, "hs_deferred_frame");
    checks++;
    if (code !== 4'h9) begin
      failures++;
      $display("FAIL hs_deferred_commit got=%h exp=9", code);
    end
  endtask

  task automatic test_lz_blank();
    int lit[4];
    enable = 1'b0;
    step();
    lz_blank_en = 1'b1;
    offer(16'h0070, 4'b0000);
    step();
    load_if.load_valid = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) lit[k] = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL lz_0070 cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
      end
      for (int k = 0; k < 4; k++) if (!anode_n[k]) lit[k]++;
    end
    checks++;
    if (lit[3] != 0 || lit[2] != 0 || lit[1] != 2 * DWELL || lit[0] != 2 * DWELL) begin
      failures++;
      $display("FAIL lz_0070_lit got=%0d,%0d,%0d,%0d exp=0,0,8,8", lit[3], lit[2], lit[1], lit[0]);
    end
    enable = 1'b0;
    offer(16'h0000, 4'b0000);
    step();
    load_if.load_valid = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) lit[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL lz_0000 cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
      end
      for (int k = 0; k < 4; k++) if (!anode_n[k]) lit[k]++;
    end
    checks++;
    if (lit[3] + lit[2] + lit[1] != 0 || lit[0] != DWELL) begin
      failures++;
      $display("FAIL lz_0000_lit got=%0d,%0d,%0d,%0d exp=0,0,0,4", lit[3], lit[2], lit[1], lit[0]);
    end
  endtask

  task automatic test_dp();
    int dp_low;
    enable = 1'b0;
    step();
    lz_blank_en = 1'b0;
    offer(16'h5A5A, 4'b0010);
    step();
    load_if.load_valid = 1'b0;
    enable = 1'b1;
    dp_low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL dp cyc=%0d got=%h exp=%h", i, act_vec, exp_vec());
      end
      if (!dp_n) begin
        dp_low++;
        checks++;
        if (anode_n !== 4'b1101) begin
          failures++;
          $display("FAIL dp_digit cyc=%0d anode_n=%b exp=1101", i, anode_n);
        end
      end
    end
    checks++;
    if (dp_low != 2 * DWELL) begin
      failures++;
      $display("FAIL dp_count got=%0d exp=%0d", dp_low, 2 * DWELL);
    end
  endtask

  task automatic test_enable_toggle();
    run_to(9, "en_wait");
    enable = 1'b0;
    step();
    checks++;
    if (anode_n !== 4'hF) begin
      failures++;
      $display("FAIL en_off anode_n=%b exp=1111", anode_n);
    end
    repeat (3) step();
    enable = 1'b1;
    for (int i = 0; i < BLANK; i++) begin
      step();
      checks++;
      if (anode_n !== 4'hF) begin
        failures++;
        $display("FAIL en_blank cyc=%0d anode_n=%b exp=1111", i, anode_n);
      end
    end
    step();
    checks++;
    if (anode_n !== 4'hE) begin
      failures++;
      $display("FAIL en_restart anode_n=%b exp=1110", anode_n);
    end
    run_to(0, "en_run");
  endtask

  task automatic test_rst_midframe();
    offer(16'h7777, 4'b1111);
    step();
    load_if.load_valid = 1'b0;
    run_to(15, "rst_wait");
    rst = 1'b1;
    step();
    checks++;
    if (anode_n !== 4'hF || code !== 4'h0 || dp_n !== 1'b1 || load_if.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid anode_n=%b code=%h dp_n=%b ready=%b exp=1111,0,1,0",
               anode_n, code, dp_n, load_if.load_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (load_if.load_ready !== 1'b1 || code !== 4'h0 || anode_n !== 4'hF) begin
      failures++;
      $display("FAIL rst_restart ready=%b code=%h anode_n=%b exp=1,0,1111",
               load_if.load_ready, code, anode_n);
    end
    step();
    step();
    checks++;
    if (anode_n !== 4'hE || dp_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_first_digit anode_n=%b dp_n=%b exp=1110,1", anode_n, dp_n);
    end
    run_to(0, "rst_run");
  endtask

  task automatic test_random();
    logic [15:0] masks[4];
    masks[0] = 16'hFFFF;
    masks[1] = 16'h00FF;
    masks[2] = 16'h000F;
    masks[3] = 16'h0F00;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 3) == 0)
        offer(16'($urandom) & masks[$urandom_range(0, 3)], 4'($urandom));
      else
        load_if.load_valid = 1'b0;
      if ($urandom_range(0, 79) == 0) begin
        enable = ~enable;
        if (!enable) lz_blank_en = 1'($urandom);
      end
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h pos=%0d", i, act_vec, exp_vec(), m_pos);
      end
    end
    load_if.load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_lz_blank();
    test_dp();
    test_enable_toggle();
    test_rst_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
